reg_snapshot_tx: RTL
====================

// Module: reg_snapshot_tx
// PURPOSE
//  Read-side counterpart of the 16-bit load register: on a read request, snapshots the register's
//  output word and transmits it LSB-first over a 1-wire UART-style serial link.
//  Used to expose CPU registers (A, D, PC) to an external debug probe without stalling the CPU.
//  Sits beside each register; data_in is wired directly to that register's data output.
// PARAMETERS
//  WIDTH         16  bits per snapshot word; legal WIDTH >= 1
//  CLKS_PER_BIT  4   clk cycles each serial bit is held; legal CLKS_PER_BIT >= 1
// PORTS
//  clk     in   1      system clock; all state changes on rising edge
//  rst_n   in   1      asynchronous, active-low reset
//  data_in in   WIDTH  live register value to be read
//  rd_req  in   1      level request; requester holds high until rd_ack
//  rd_ack  out  1      1-cycle pulse: request accepted, data_in captured
//  tx_out  out  1      serial line; idles high
//  busy    out  1      high while a frame is on the line
//  done    out  1      1-cycle pulse: frame complete
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, tx_out=1, busy=0, rd_ack=0, done=0, counters=0, shift reg=0.
//   Reset asserted mid-frame aborts the frame immediately; no done pulse is issued.
//  All outputs are registered. Frame = start(0), WIDTH data bits LSB first, stop(1).
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//  IDLE: tx_out=1. rd_req=1 at edge E: shreg<=data_in, rd_ack<=1 (exactly 1 cycle), busy<=1,
//   tx_out<=0, state<=START. rd_req is sampled only in IDLE; it is ignored in all other states.
//  Bit timing, counted in cycles after E (C=CLKS_PER_BIT, W=WIDTH):
//   start bit: cycles 1..C; data bit i: cycles C*(i+1)+1 .. C*(i+2); stop: C*(W+1)+1 .. C*(W+2).
//  Edge C*(W+2): state<=IDLE, busy<=0, done<=1 (1 cycle), tx_out stays 1.
//  busy is high for exactly (W+2)*C cycles per frame.
//  Back-to-back: with rd_req still high, the next accept happens at edge C*(W+2)+1.
//   The line therefore always idles high for >= 1 cycle between frames.
//  Snapshot: later changes to data_in (register reloads) do not affect the frame in flight.
//  Counters:
//   bit timer, $clog2(C) bits (min 1), wraps at C-1;
//   bit index, $clog2(W+1) bits, counts 0..W-1 in DATA.
//   Shift right on each data-bit boundary; tx_out = shreg[0] during DATA.
//  C=1 is legal: one bit per cycle, same state sequence.
//  rd_req deasserted before the accept edge: nothing happens; no partial capture.
// STRUCTURE
//  Shared include (hack_defs.vh):
//   state encoding localparams S_IDLE=2'd0, S_START=2'd1, S_DATA=2'd2, S_STOP=2'd3;
//   default WIDTH=16.
//  One sub-module: bit_timer (clk, rst_n, en, tick). tick pulses on the last cycle of each bit
//   period and restarts when en falls.
//  FSM, shift register and handshake live in reg_snapshot_tx.
// TESTING (WIDTH=16, CLKS_PER_BIT=4 unless noted)
//  1 Reset: rst_n=0 -> tx_out=1, busy=0, rd_ack=0, done=0.
//    Release rst_n, rd_req=0 for 20 cycles -> line stays 1.
//  2 Single frame: data_in=16'hA5C3, rd_req for 1 cycle.
//    -> rd_ack 1 cycle; serial line samples 0,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1,
//       each bit held 4 cycles.
//    -> busy high exactly 72 cycles; done pulses once.
//  3 Snapshot: accept 16'h0001, then drive data_in=16'hFFFF on the next cycle
//    -> received word is 16'h0001.
//  4 Back-to-back: hold rd_req high, data 16'h1234 then 16'h8000
//    -> two frames, each with its own rd_ack; exactly 1 idle-high cycle between stop and next start.
//  5 Abort: assert rst_n=0 during data bit 5
//    -> tx_out=1 and busy=0 in the same cycle, no done.
//    -> A fresh request after release sends a complete frame.
//  6 C=1, data_in=16'hFFFF -> frame length 18 cycles; line reads 0 then seventeen 1s.

Source files
------------

// File: rtl/reg_snapshot_tx_pkg.sv
// Shared types and defaults for the register snapshot serial transmitter.
package reg_snapshot_tx_pkg;

  localparam int unsigned DefaultWidth      = 16;
  localparam int unsigned DefaultClksPerBit = 4;

  // Frame sequencing states; encoding is fixed so probes can decode it.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_e;

  // Counter width helper: a counter always needs at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/reg_snapshot_tx_bit_timer.sv
// Bit-period timer: tick marks the last cycle of each serial bit period.
// The count is held at zero while en is low, so every frame starts aligned.
module reg_snapshot_tx_bit_timer
  import reg_snapshot_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = clog2_min1(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  // Count cycles within a bit period; wrap at the last cycle, restart when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || (cnt_q == CntLast)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == CntLast);

endmodule

// File: rtl/reg_snapshot_tx.sv
// Snapshots a register value on a read request and shifts it out LSB-first as a
// start(0) / data / stop(1) frame on a single idle-high line.
module reg_snapshot_tx
  import reg_snapshot_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW = clog2_min1(WIDTH + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             tick;

  reg_snapshot_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q != StIdle),
    .tick  (tick)
  );

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  // Frame sequencing: the next line level is computed one edge ahead so tx_out is registered.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (rd_req) begin
          shreg_d = data_in;
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          // Present bit 0 and pre-shift so shreg[0] is always the next bit to send.
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (idx_q == IdxLast) begin
            tx_d    = 1'b1;
            idx_d   = '0;
            state_d = StStop;
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_ack = ack_q;
  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
